// File: rtl/spi_minion_array.sv
// Array of independent SPI mode-0 minion channels with per-channel synchronisers,
// one-entry receive buffer and valid/ready stream interfaces on the system clock.
module spi_minion_array #(
  parameter int unsigned NCH         = 2,
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NCH-1:0]         cs,
  input  logic [NCH-1:0]         sclk,
  input  logic [NCH-1:0]         mosi,
  output logic [NCH-1:0]         miso,
  output logic [NCH*WIDTH-1:0]   recv_msg,
  output logic [NCH-1:0]         recv_val,
  input  logic [NCH-1:0]         recv_rdy,
  input  logic [NCH*WIDTH-1:0]   send_msg,
  input  logic [NCH-1:0]         send_val,
  output logic [NCH-1:0]         send_rdy,
  output logic [NCH-1:0]         overflow,
  output logic [NCH-1:0]         underflow
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic {IDLE, ACTIVE} state_e;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   cs_last_q, cs_last_d;
    logic                   sclk_last_q, sclk_last_d;
    state_e                 state_q, state_d;
    logic [WIDTH-1:0]       tx_q, tx_d;
    logic [WIDTH-2:0]       rx_q, rx_d;
    logic [WIDTH-1:0]       buf_q, buf_d;
    logic                   buf_val_q, buf_val_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   load_pend_q, load_pend_d;

    logic             cs_s, sclk_s, mosi_s;
    logic             cs_fall, cs_rise, sclk_rise, sclk_fall;
    logic             load, done, deq;
    logic             send_rdy_c, underflow_c, overflow_c;
    logic [WIDTH-1:0] rx_word;

    always_comb begin
      cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs[i]};
      sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk[i]};
      mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi[i]};
      cs_s        = cs_sync_q[SYNC_STAGES-1];
      sclk_s      = sclk_sync_q[SYNC_STAGES-1];
      mosi_s      = mosi_sync_q[SYNC_STAGES-1];
      cs_last_d   = cs_s;
      sclk_last_d = sclk_s;
      cs_fall     = cs_last_q & ~cs_s;
      cs_rise     = ~cs_last_q & cs_s;
      sclk_rise   = ~sclk_last_q & sclk_s;
      sclk_fall   = sclk_last_q & ~sclk_s;
      rx_word     = {rx_q, mosi_s};
      deq         = buf_val_q & recv_rdy[i];

      state_d     = state_q;
      tx_d        = tx_q;
      rx_d        = rx_q;
      cnt_d       = cnt_q;
      load_pend_d = load_pend_q;
      buf_d       = buf_q;
      buf_val_d   = buf_val_q;
      load        = 1'b0;
      done        = 1'b0;
      send_rdy_c  = 1'b0;
      underflow_c = 1'b0;
      overflow_c  = 1'b0;

      case (state_q)
        IDLE: begin
          if (cs_fall) begin
            state_d = ACTIVE;
            load    = 1'b1;
          end
        end
        ACTIVE: begin
          if (cs_rise) begin
            state_d     = IDLE;
            tx_d        = '0;
            rx_d        = '0;
            cnt_d       = '0;
            load_pend_d = 1'b0;
          end else if (sclk_rise) begin
            rx_d = rx_word[WIDTH-2:0];
            if (cnt_q == CW'(WIDTH - 1)) begin
              cnt_d       = '0;
              done        = 1'b1;
              load_pend_d = 1'b1;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end else if (sclk_fall) begin
            // The first fall after a completed word reloads instead of shifting.
            if (load_pend_q) begin
              load        = 1'b1;
              load_pend_d = 1'b0;
            end else begin
              tx_d = {tx_q[WIDTH-2:0], 1'b0};
            end
          end
        end
        default: state_d = IDLE;
      endcase

      if (load) begin
        if (send_val[i]) begin
          tx_d       = send_msg[i*WIDTH +: WIDTH];
          send_rdy_c = 1'b1;
        end else begin
          tx_d        = '0;
          underflow_c = 1'b1;
        end
      end

      if (done) begin
        if (!buf_val_q || deq) begin
          buf_d     = rx_word;
          buf_val_d = 1'b1;
        end else begin
          overflow_c = 1'b1;
        end
      end else if (deq) begin
        buf_val_d = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        cs_sync_q   <= '0;
        sclk_sync_q <= '0;
        mosi_sync_q <= '0;
        cs_last_q   <= 1'b0;
        sclk_last_q <= 1'b0;
        state_q     <= IDLE;
        tx_q        <= '0;
        rx_q        <= '0;
        buf_q       <= '0;
        buf_val_q   <= 1'b0;
        cnt_q       <= '0;
        load_pend_q <= 1'b0;
      end else begin
        cs_sync_q   <= cs_sync_d;
        sclk_sync_q <= sclk_sync_d;
        mosi_sync_q <= mosi_sync_d;
        cs_last_q   <= cs_last_d;
        sclk_last_q <= sclk_last_d;
        state_q     <= state_d;
        tx_q        <= tx_d;
        rx_q        <= rx_d;
        buf_q       <= buf_d;
        buf_val_q   <= buf_val_d;
        cnt_q       <= cnt_d;
        load_pend_q <= load_pend_d;
      end
    end

    assign miso[i]                    = (state_q == ACTIVE) ? tx_q[WIDTH-1] : 1'b0;
    assign recv_msg[i*WIDTH +: WIDTH] = buf_q;
    assign recv_val[i]                = buf_val_q;
    assign send_rdy[i]                = send_rdy_c;
    assign underflow[i]               = underflow_c;
    assign overflow[i]                = overflow_c;
  end

endmodule

// File: tb/tb_spi_minion_array.sv
// Directed bench for spi_minion_array (NCH=2, WIDTH=8, SYNC_STAGES=2) with
// hand-computed expected words, miso bit patterns and pulse counts.
module tb_spi_minion_array;

  logic        clk;
  logic        reset;
  logic [1:0]  cs, sclk, mosi, miso;
  logic [15:0] recv_msg, send_msg;
  logic [1:0]  recv_val, recv_rdy, send_val, send_rdy, overflow, underflow;

  int n_chk  = 0;
  int n_fail = 0;

  int         srdy_n[2], undf_n[2], ovf_n[2], hs_n[2];
  logic [7:0] rx_log[2][8];
  logic [7:0] mb;
  int         lat;

  spi_minion_array #(.NCH(2), .WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset), .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso),
    .recv_msg(recv_msg), .recv_val(recv_val), .recv_rdy(recv_rdy),
    .send_msg(send_msg), .send_val(send_val), .send_rdy(send_rdy),
    .overflow(overflow), .underflow(underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters and receive log, sampled mid-cycle.
  always @(negedge clk) begin
    for (int c = 0; c < 2; c++) begin
      if (send_rdy[c])  srdy_n[c]++;
      if (underflow[c]) undf_n[c]++;
      if (overflow[c])  ovf_n[c]++;
      if (recv_val[c] && recv_rdy[c]) begin
        if (hs_n[c] < 8) rx_log[c][hs_n[c]] = recv_msg[c*8 +: 8];
        hs_n[c]++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr();
    for (int c = 0; c < 2; c++) begin
      srdy_n[c] = 0; undf_n[c] = 0; ovf_n[c] = 0; hs_n[c] = 0;
      for (int k = 0; k < 8; k++) rx_log[c][k] = 8'h00;
    end
  endtask

  task automatic start(input int ch);
    cs[ch] = 1'b0;
    tick(6);
  endtask

  // Sends nb bits MSB first; with end_cs, cs rises while sclk is still high after the last bit.
  task automatic send_bits(input int ch, input logic [7:0] data, input int nb, input bit end_cs,
                           output logic [7:0] mbits, output int lt);
    mbits = '0;
    lt    = 0;
    for (int k = 0; k < nb; k++) begin
      mosi[ch] = data[7-k];
      tick(4);
      mbits    = {mbits[6:0], miso[ch]};
      sclk[ch] = 1'b1;
      lt       = 0;
      for (int w = 1; w <= 4; w++) begin
        tick(1);
        if (recv_val[ch] && lt == 0) lt = w;
      end
      if (k == nb - 1 && end_cs) begin
        cs[ch] = 1'b1;
        tick(4);
        sclk[ch] = 1'b0;
        tick(4);
      end else begin
        sclk[ch] = 1'b0;
      end
    end
  endtask

  initial begin
    reset = 1'b0; cs = 2'b11; sclk = 2'b00; mosi = 2'b00;
    send_msg = '0; send_val = 2'b00; recv_rdy = 2'b00;
    clr();
    tick(3);
    chk("rst_miso", miso, 0);
    chk("rst_recv_val", recv_val, 0);
    chk("rst_recv_msg", recv_msg, 0);
    chk("rst_pulses", {send_rdy, overflow, underflow}, 0);
    reset = 1'b1;
    tick(6);

    // Ch0: transmit 0xA5 while receiving 0x3C.
    clr();
    send_msg[7:0] = 8'hA5; send_val[0] = 1'b1;
    start(0);
    send_val[0] = 1'b0;
    send_bits(0, 8'h3C, 8, 1, mb, lat);
    chk("t1_miso_bits", mb, 8'hA5);
    chk("t1_latency_ok", (lat >= 1 && lat <= 4), 1);
    chk("t1_recv_val", recv_val[0], 1);
    chk("t1_recv_msg", recv_msg[7:0], 8'h3C);
    chk("t1_send_rdy_cnt", srdy_n[0], 1);
    chk("t1_underflow_cnt", undf_n[0], 0);
    recv_rdy[0] = 1'b1; tick(1); recv_rdy[0] = 1'b0; tick(1);
    chk("t1_deq_val", recv_val[0], 0);
    chk("t1_deq_word", rx_log[0][0], 8'h3C);

    // Ch1: back-to-back words under one cs; ch0 must stay untouched.
    clr();
    recv_rdy[1] = 1'b1;
    start(1);
    send_bits(1, 8'h01, 8, 0, mb, lat);
    send_bits(1, 8'h80, 8, 1, mb, lat);
    recv_rdy[1] = 1'b0;
    chk("t2_hs_cnt", hs_n[1], 2);
    chk("t2_word0", rx_log[1][0], 8'h01);
    chk("t2_word1", rx_log[1][1], 8'h80);
    chk("t2_ovf_cnt", ovf_n[1], 0);
    chk("t2_ch0_msg", recv_msg[7:0], 8'h3C);
    chk("t2_ch0_val", recv_val[0], 0);
    chk("t2_ch0_pulses", srdy_n[0] + undf_n[0] + ovf_n[0] + hs_n[0], 0);
    chk("t2_ch0_miso", miso[0], 0);

    // Ch0: buffer held full, second word dropped.
    clr();
    start(0);
    send_bits(0, 8'h11, 8, 0, mb, lat);
    send_bits(0, 8'h22, 8, 1, mb, lat);
    chk("t3_ovf_cnt", ovf_n[0], 1);
    chk("t3_recv_val", recv_val[0], 1);
    chk("t3_recv_msg", recv_msg[7:0], 8'h11);
    recv_rdy[0] = 1'b1; tick(1); recv_rdy[0] = 1'b0; tick(1);
    chk("t3_deq_word", rx_log[0][0], 8'h11);
    chk("t3_deq_cnt", hs_n[0], 1);
    chk("t3_deq_val", recv_val[0], 0);

    // Ch0: nothing to send at cs fall.
    clr();
    recv_rdy[0] = 1'b1;
    start(0);
    send_bits(0, 8'h96, 8, 1, mb, lat);
    chk("t4_miso_bits", mb, 8'h00);
    chk("t4_underflow_cnt", undf_n[0], 1);
    chk("t4_send_rdy_cnt", srdy_n[0], 0);
    chk("t4_word", rx_log[0][0], 8'h96);

    // Ch0: aborted partial word, then a full word.
    clr();
    start(0);
    send_bits(0, 8'hFF, 5, 1, mb, lat);
    tick(4);
    chk("t5_partial_hs", hs_n[0], 0);
    chk("t5_partial_val", recv_val[0], 0);
    start(0);
    send_bits(0, 8'hF0, 8, 1, mb, lat);
    chk("t5_full_hs", hs_n[0], 1);
    chk("t5_full_word", rx_log[0][0], 8'hF0);
    recv_rdy[0] = 1'b0;
    chk("t5_msg_kept", recv_msg[7:0], 8'hF0);

    // Ch0: reset mid-transaction.
    clr();
    send_msg[7:0] = 8'hFF; send_val[0] = 1'b1;
    start(0);
    send_val[0] = 1'b0;
    send_bits(0, 8'hAA, 3, 0, mb, lat);
    tick(4);
    chk("t6_pre_miso", miso[0], 1);
    reset = 1'b0;
    #2;
    chk("t6_rst_miso", miso, 0);
    chk("t6_rst_val", recv_val, 0);
    chk("t6_rst_msg", recv_msg, 0);
    chk("t6_rst_pulses", {send_rdy, overflow, underflow}, 0);
    tick(2);
    reset = 1'b1;
    send_msg[7:0] = 8'h5A; send_val[0] = 1'b1;
    clr();
    tick(8);
    chk("t6_no_restart_rdy", srdy_n[0], 0);
    chk("t6_no_restart_miso", miso[0], 0);
    cs[0] = 1'b1; mosi[0] = 1'b0;
    tick(6);
    clr();
    recv_rdy[0] = 1'b1;
    start(0);
    send_val[0] = 1'b0;
    send_bits(0, 8'h5A, 8, 1, mb, lat);
    recv_rdy[0] = 1'b0;
    chk("t6_hs_cnt", hs_n[0], 1);
    chk("t6_word", rx_log[0][0], 8'h5A);
    chk("t6_miso_bits", mb, 8'h5A);
    chk("t6_send_rdy_cnt", srdy_n[0], 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
